// File: rtl/mem_store_aligner_if.sv
// Store-request and byte-banked memory-beat bundle for mem_store_aligner.
// master = request issuer / memory model side, slave = the aligner.
interface mem_store_aligner_if #(
  parameter int unsigned NBANKS = 4,
  parameter int unsigned BANK_W = 8,
  parameter int unsigned ADDR_W = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr;
  logic [1:0]                 req_size;
  logic [NBANKS*BANK_W-1:0]   req_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [ADDR_W-1:0]          mem_addr;
  logic [NBANKS*BANK_W-1:0]   mem_wdata;
  logic [NBANKS-1:0]          mem_be;
  logic                       mem_last;
  logic                       err;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last, err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last, err
  );
endinterface

// File: rtl/mem_store_aligner.sv
// Registered store aligner: rotates store data onto byte banks, builds byte enables and
// splits row-crossing stores into two memory beats with valid/ready flow control.
module mem_store_aligner #(
  parameter int unsigned NBANKS = 4,
  parameter int unsigned BANK_W = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_store_aligner_if.slave bus
);
  localparam int unsigned OFF_W  = $clog2(NBANKS);
  localparam int unsigned DATA_W = NBANKS * BANK_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBeat0 = 2'd1;
  localparam logic [1:0] StBeat1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NBANKS-1:0] be0_q, be0_d;
  logic [NBANKS-1:0] be1_q, be1_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              split_q, split_d;
  logic              err_q, err_d;

  logic                mem_valid, mem_last, beat_done, req_ready, accept, size_ok;
  logic [OFF_W-1:0]    off;
  int unsigned         nbytes, shamt;
  logic [DATA_W-1:0]   rot;
  logic [2*NBANKS-1:0] lane_mask;

  // Outputs come only from registered state, so nothing on req_* reaches mem_*.
  always_comb begin
    mem_valid = (state_q == StBeat0) || (state_q == StBeat1);
    mem_last  = (state_q == StBeat1) || ((state_q == StBeat0) && !split_q);
    beat_done = mem_valid && bus.mem_ready;
    req_ready = (state_q == StIdle) || (beat_done && mem_last);
  end

  assign bus.mem_valid = mem_valid;
  assign bus.mem_last  = mem_last;
  assign bus.req_ready = req_ready;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = (state_q == StBeat1) ? be1_q : be0_q;
  assign bus.mem_addr  = (state_q == StBeat1) ? row_q + ADDR_W'(NBANKS) : row_q;
  assign bus.err       = err_q;

  always_comb begin
    off     = bus.req_addr[OFF_W-1:0];
    nbytes  = 32'd1 << bus.req_size;
    size_ok = 32'(bus.req_size) <= OFF_W;
    shamt   = 32'(off) * BANK_W;
    // A shift by DATA_W yields zero, which keeps the off == 0 case a plain copy.
    rot     = (bus.req_data << shamt) | (bus.req_data >> (DATA_W - shamt));
    // Lanes past NBANKS belong to the next row, i.e. the second beat.
    for (int unsigned i = 0; i < 2 * NBANKS; i++) begin
      lane_mask[i] = (i >= 32'(off)) && (i < 32'(off) + nbytes);
    end
    accept = bus.req_valid && req_ready;
  end

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    be0_d   = be0_q;
    be1_d   = be1_q;
    row_d   = row_q;
    split_d = split_q;
    err_d   = 1'b0;

    case (state_q)
      StIdle:  ;
      StBeat0: if (beat_done) state_d = split_q ? StBeat1 : StIdle;
      StBeat1: if (beat_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (size_ok) begin
        state_d = StBeat0;
        wdata_d = rot;
        be0_d   = lane_mask[NBANKS-1:0];
        be1_d   = lane_mask[2*NBANKS-1:NBANKS];
        split_d = |lane_mask[2*NBANKS-1:NBANKS];
        row_d   = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end else begin
        state_d = StIdle;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wdata_q <= '0;
      be0_q   <= '0;
      be1_q   <= '0;
      row_q   <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      be0_q   <= be0_d;
      be1_q   <= be1_d;
      row_q   <= row_d;
      split_q <= split_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_store_aligner.sv
// Self-checking bench for mem_store_aligner: directed table, hand-written corner sequences
// and randomized traffic against a byte-address reference model.
module tb_mem_store_aligner;
  localparam int unsigned NB = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_store_aligner_if #(.NBANKS(NB), .BANK_W(BW), .ADDR_W(AW)) bus ();

  mem_store_aligner #(.NBANKS(NB), .BANK_W(BW), .ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    int          stall;
    int          nb;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd;
    logic [3:0]  be0;
    logic [3:0]  be1;
  } vec_t;

  vec_t  vecs[8];
  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the stored bytes by absolute address; each byte goes to bank addr%4 of
  // whichever row it falls in. Lane k carries byte (k - off) mod 4 of the store data.
  function automatic void model(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                                output int nb, output beat_t b0, output beat_t b1);
    int          n;
    logic [31:0] ba;
    logic [31:0] wd;
    n = 1 << s;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*((k - int'(a[1:0]) + 4) % 4) +: 8];
    b0 = '{addr: a & ~32'h3, wdata: wd, be: 4'b0, last: 1'b1};
    b1 = '{addr: (a + 32'(n) - 32'd1) & ~32'h3, wdata: wd, be: 4'b0, last: 1'b1};
    for (int j = 0; j < n; j++) begin
      ba = a + 32'(j);
      if ((ba & ~32'h3) == b0.addr) b0.be[ba[1:0]] = 1'b1;
      else b1.be[ba[1:0]] = 1'b1;
    end
    nb = (s > 2'd2) ? 0 : ((b1.be != 4'b0) ? 2 : 1);
    b0.last = (nb == 1);
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_size  = s;
    bus.req_data  = d;
  endtask

  // One request from idle; each beat is stalled v.stall cycles before mem_ready rises.
  task automatic do_req(input int idx, input vec_t v);
    @(negedge clk);
    drive_req(v.addr, v.size, v.data);
    bus.mem_ready = 1'b0;
    #1 chk($sformatf("v%0d ready_idle", idx), bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int b = 0; b < v.nb; b++) begin
      for (int c = 0; c <= v.stall; c++) begin
        bus.mem_ready = (c == v.stall);
        #1;
        chk($sformatf("v%0d b%0d valid", idx, b), bus.mem_valid, 1);
        chk($sformatf("v%0d b%0d addr", idx, b), bus.mem_addr, (b == 0) ? v.a0 : v.a1);
        chk($sformatf("v%0d b%0d wdata", idx, b), bus.mem_wdata, v.wd);
        chk($sformatf("v%0d b%0d be", idx, b), bus.mem_be, (b == 0) ? v.be0 : v.be1);
        chk($sformatf("v%0d b%0d last", idx, b), bus.mem_last, (b == v.nb - 1));
        chk($sformatf("v%0d b%0d req_ready", idx, b), bus.req_ready,
            (c == v.stall) && (b == v.nb - 1));
        @(negedge clk);
      end
    end
    bus.mem_ready = 1'b0;
    #1 chk($sformatf("v%0d idle_after", idx), bus.mem_valid, 0);
  endtask

  initial begin
    int    nb;
    beat_t b0, b1;
    logic  err_exp, rdy_exp, accepted;
    int    r;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_data  = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst mem_valid", bus.mem_valid, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst mem_be", bus.mem_be, 0);
    chk("rst mem_last", bus.mem_last, 0);
    chk("rst err", bus.err, 0);
    chk("rst req_ready", bus.req_ready, 1);

    vecs[0] = '{addr: 32'h100, size: 2'd2, data: 32'hAABBCCDD, stall: 0, nb: 1,
                a0: 32'h100, a1: 32'h0, wd: 32'hAABBCCDD, be0: 4'b1111, be1: 4'b0000};
    vecs[1] = '{addr: 32'h103, size: 2'd0, data: 32'h000000EE, stall: 0, nb: 1,
                a0: 32'h100, a1: 32'h0, wd: 32'hEE000000, be0: 4'b1000, be1: 4'b0000};
    vecs[2] = '{addr: 32'h1003, size: 2'd1, data: 32'h00001234, stall: 0, nb: 2,
                a0: 32'h1000, a1: 32'h1004, wd: 32'h34000012, be0: 4'b1000, be1: 4'b0001};
    vecs[3] = '{addr: 32'h202, size: 2'd2, data: 32'h11223344, stall: 3, nb: 2,
                a0: 32'h200, a1: 32'h204, wd: 32'h33441122, be0: 4'b1100, be1: 4'b0011};
    vecs[4] = '{addr: 32'hFFFFFFFE, size: 2'd2, data: 32'hCAFEF00D, stall: 1, nb: 2,
                a0: 32'hFFFFFFFC, a1: 32'h0, wd: 32'hF00DCAFE, be0: 4'b1100, be1: 4'b0011};
    vecs[5] = '{addr: 32'h2, size: 2'd1, data: 32'h0000BEEF, stall: 0, nb: 1,
                a0: 32'h0, a1: 32'h0, wd: 32'hBEEF0000, be0: 4'b1100, be1: 4'b0000};
    vecs[6] = '{addr: 32'h11, size: 2'd0, data: 32'h00000055, stall: 2, nb: 1,
                a0: 32'h10, a1: 32'h0, wd: 32'h00005500, be0: 4'b0010, be1: 4'b0000};
    vecs[7] = '{addr: 32'h1, size: 2'd1, data: 32'h0000ABCD, stall: 0, nb: 1,
                a0: 32'h0, a1: 32'h0, wd: 32'h00ABCD00, be0: 4'b0110, be1: 4'b0000};
    for (int i = 0; i < 8; i++) do_req(i, vecs[i]);

    // Back-to-back: second request accepted as the first one's only beat completes.
    @(negedge clk);
    drive_req(32'h100, 2'd2, 32'hAABBCCDD);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    drive_req(32'h203, 2'd0, 32'h00000077);
    #1;
    chk("b2b a addr", bus.mem_addr, 32'h100);
    chk("b2b a wdata", bus.mem_wdata, 32'hAABBCCDD);
    chk("b2b a be", bus.mem_be, 4'b1111);
    chk("b2b a ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("b2b b valid", bus.mem_valid, 1);
    chk("b2b b addr", bus.mem_addr, 32'h200);
    chk("b2b b wdata", bus.mem_wdata, 32'h77000000);
    chk("b2b b be", bus.mem_be, 4'b1000);
    chk("b2b b last", bus.mem_last, 1);
    @(negedge clk);
    #1 chk("b2b idle", bus.mem_valid, 0);

    // Illegal size: one-cycle err, no beat.
    @(negedge clk);
    drive_req(32'h40, 2'd3, 32'h12345678);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("ill err", bus.err, 1);
    chk("ill valid", bus.mem_valid, 0);
    @(negedge clk);
    #1;
    chk("ill err_drop", bus.err, 0);
    chk("ill valid2", bus.mem_valid, 0);

    // Reset while the second beat of a split store is pending.
    @(negedge clk);
    drive_req(32'h1003, 2'd1, 32'h00001234);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk("rstb1 in_beat1", bus.mem_addr, 32'h1004);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstb1 valid", bus.mem_valid, 0);
    chk("rstb1 be", bus.mem_be, 0);
    chk("rstb1 ready", bus.req_ready, 1);
    @(negedge clk);
    #1 chk("rstb1 no_beat", bus.mem_valid, 0);

    // Randomized traffic with a beat scoreboard.
    exp_q.delete();
    err_exp  = 1'b0;
    accepted = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (accepted) bus.req_valid = 1'b0;
      accepted = 1'b0;
      if (!bus.req_valid && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 9);
        drive_req(($urandom_range(0, 15) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                               : 32'($urandom),
                  (r == 9) ? 2'd3 : 2'(r % 3), 32'($urandom));
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.mem_ready);
      chk("rnd mem_valid", bus.mem_valid, exp_q.size() != 0);
      chk("rnd req_ready", bus.req_ready, rdy_exp);
      chk("rnd err", bus.err, err_exp);
      if (exp_q.size() != 0) begin
        chk("rnd addr", bus.mem_addr, exp_q[0].addr);
        chk("rnd wdata", bus.mem_wdata, exp_q[0].wdata);
        chk("rnd be", bus.mem_be, exp_q[0].be);
        chk("rnd last", bus.mem_last, exp_q[0].last);
        if (bus.mem_ready) void'(exp_q.pop_front());
      end
      err_exp = 1'b0;
      if (bus.req_valid && rdy_exp) begin
        accepted = 1'b1;
        model(bus.req_addr, bus.req_size, bus.req_data, nb, b0, b1);
        if (nb == 0) err_exp = 1'b1;
        else exp_q.push_back(b0);
        if (nb == 2) exp_q.push_back(b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
